// File: rtl/lives_bar_object.sv
// Row of MAX_LIVES heart slots with its own lives counter, blink-on-loss sequence and game-over state.
// Latency: pixel outputs are registered, one cycle after pixelX/pixelY; livesLeft/gameOver follow pulses by one cycle.
// Backpressure: none; pulse inputs are sampled every cycle and the pixel stream is never stalled.
//
// Ports: clk/resetN (async active-low); pixelX/pixelY/startOfFrame from the VGA timing;
// loseLife/gainLife/restart one-cycle control pulses; offsetX/offsetY/heartIndex to the heart bitmap ROM;
// drawingRequest/RGBout to the object mux; livesLeft/gameOver as game status.
module lives_bar_object #(
    parameter int         MAX_LIVES     = 3,
    parameter int         HEART_W       = 20,
    parameter int         HEART_H       = 16,
    parameter int         GAP           = 2,
    parameter int         top_X         = 548,
    parameter int         top_Y         = 5,
    parameter logic [7:0] OBJECT_COLOR  = 8'h5b,
    parameter int         BLINK_PERIOD  = 8,
    parameter int         BLINK_TOGGLES = 6
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        loseLife,
    input  logic        gainLife,
    input  logic        restart,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic [3:0]  heartIndex,
    output logic [3:0]  livesLeft,
    output logic        gameOver
);

    localparam int PITCH = HEART_W + GAP;
    localparam int FW    = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam int TW    = $clog2(BLINK_TOGGLES + 1);

    localparam logic [3:0]    MAX4       = 4'(MAX_LIVES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_PERIOD - 1);
    localparam logic [TW-1:0] TOGGLE_END = TW'(BLINK_TOGGLES);
    localparam logic [10:0]   Y_TOP      = 11'(top_Y);
    localparam logic [10:0]   Y_BOT      = 11'(top_Y + HEART_H);

    typedef enum logic [1:0] {IDLE, BLINK, GAME_OVER} state_t;

    state_t        state, state_nx;
    logic [3:0]    lives, lives_nx;
    logic [FW-1:0] frame_cnt, frame_nx;
    logic [TW-1:0] toggle_cnt, toggle_nx;
    logic          blink_on, blink_nx;

    // State and counter register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            lives      <= MAX4;
            frame_cnt  <= '0;
            toggle_cnt <= '0;
            blink_on   <= 1'b0;
        end else begin
            state      <= state_nx;
            lives      <= lives_nx;
            frame_cnt  <= frame_nx;
            toggle_cnt <= toggle_nx;
            blink_on   <= blink_nx;
        end
    end

    // Next-state logic. restart beats everything; lose+gain together cancel out.
    always_comb begin
        state_nx  = state;
        lives_nx  = lives;
        frame_nx  = frame_cnt;
        toggle_nx = toggle_cnt;
        blink_nx  = blink_on;
        if (restart) begin
            state_nx  = IDLE;
            lives_nx  = MAX4;
            frame_nx  = '0;
            toggle_nx = '0;
            blink_nx  = 1'b0;
        end else if (!(loseLife && gainLife)) begin
            case (state)
                IDLE: begin
                    if (loseLife && lives != 4'd0) begin
                        lives_nx  = lives - 4'd1;
                        state_nx  = BLINK;
                        frame_nx  = '0;
                        toggle_nx = '0;
                        blink_nx  = 1'b0;
                    end else if (gainLife && lives < MAX4) begin
                        lives_nx = lives + 4'd1;
                    end
                end
                BLINK: begin
                    if (loseLife && lives != 4'd0) begin
                        // Another loss restarts the sequence on the next slot down
                        lives_nx  = lives - 4'd1;
                        frame_nx  = '0;
                        toggle_nx = '0;
                        blink_nx  = 1'b0;
                    end else if (gainLife) begin
                        if (lives < MAX4) begin
                            lives_nx = lives + 4'd1;
                        end
                        state_nx  = IDLE;
                        frame_nx  = '0;
                        toggle_nx = '0;
                        blink_nx  = 1'b0;
                    end else if (toggle_cnt == TOGGLE_END) begin
                        state_nx  = (lives == 4'd0) ? GAME_OVER : IDLE;
                        frame_nx  = '0;
                        toggle_nx = '0;
                        blink_nx  = 1'b0;
                    end else if (startOfFrame) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_nx  = '0;
                            blink_nx  = ~blink_on;
                            toggle_nx = toggle_cnt + TW'(1);
                        end else begin
                            frame_nx = frame_cnt + FW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        livesLeft = lives;
        gameOver  = (state == GAME_OVER);
    end

    // Slot hit test: each slot compared against its own constant bounds.
    logic        hit;
    logic [3:0]  hit_idx;
    logic [10:0] hit_left;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = 4'd0;
        hit_left = 11'd0;
        for (int i = 0; i < MAX_LIVES; i++) begin
            if (pixelX >= 11'(top_X + i * PITCH) &&
                pixelX <  11'(top_X + i * PITCH + HEART_W) &&
                pixelY >= Y_TOP && pixelY < Y_BOT &&
                state != GAME_OVER &&
                ((4'(i) < lives) ||
                 (state == BLINK && 4'(i) == lives && blink_on))) begin
                hit      = 1'b1;
                hit_idx  = 4'(i);
                hit_left = 11'(top_X + i * PITCH);
            end
        end
    end

    // Registered pixel outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drawingRequest <= 1'b0;
            RGBout         <= 8'h00;
            offsetX        <= 11'd0;
            offsetY        <= 11'd0;
            heartIndex     <= 4'd0;
        end else if (hit) begin
            drawingRequest <= 1'b1;
            RGBout         <= OBJECT_COLOR;
            offsetX        <= pixelX - hit_left;
            offsetY        <= pixelY - Y_TOP;
            heartIndex     <= hit_idx;
        end else begin
            drawingRequest <= 1'b0;
            RGBout         <= 8'hFF;
            offsetX        <= 11'd0;
            offsetY        <= 11'd0;
            heartIndex     <= 4'd0;
        end
    end

endmodule

// File: tb/tb_lives_bar_object.sv
// Randomized bench for lives_bar_object against an arithmetic reference model.
// Latency: model predicts pixel outputs one cycle after the pixel is driven.
// Backpressure: none; pulses are spaced so the DUT settles between events.
module tb_lives_bar_object;

    localparam int         MAXL = 3;
    localparam int         W    = 20;
    localparam int         H    = 16;
    localparam int         G    = 2;
    localparam int         TX   = 548;
    localparam int         TY   = 5;
    localparam logic [7:0] COL  = 8'h5b;
    localparam int         P    = 8;
    localparam int         T    = 6;

    logic        clk;
    logic        resetN;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, loseLife, gainLife, restart;
    logic [10:0] offsetX, offsetY;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic [3:0]  heartIndex, livesLeft;
    logic        gameOver;

    lives_bar_object #(
        .MAX_LIVES(MAXL), .HEART_W(W), .HEART_H(H), .GAP(G), .top_X(TX), .top_Y(TY),
        .OBJECT_COLOR(COL), .BLINK_PERIOD(P), .BLINK_TOGGLES(T)
    ) dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .loseLife(loseLife), .gainLife(gainLife), .restart(restart),
        .offsetX(offsetX), .offsetY(offsetY), .drawingRequest(drawingRequest), .RGBout(RGBout),
        .heartIndex(heartIndex), .livesLeft(livesLeft), .gameOver(gameOver)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: lives count, mode (0 idle, 1 blink, 2 game over), frames seen in this blink.
    int m_lives, m_mode, m_bf;

    task automatic model_reset();
        m_lives = MAXL;
        m_mode  = 0;
        m_bf    = 0;
    endtask

    task automatic model_event(input bit lose, input bit gain, input bit rs, input bit sof);
        if (rs) begin
            model_reset();
        end else if (lose && gain) begin
        end else if (m_mode != 2) begin
            if (lose && m_lives > 0) begin
                m_lives--;
                m_mode = 1;
                m_bf   = 0;
            end else if (gain) begin
                if (m_lives < MAXL) m_lives++;
                m_mode = 0;
                m_bf   = 0;
            end else if (sof && m_mode == 1) begin
                m_bf++;
                if (m_bf == P * T) begin
                    m_mode = (m_lives == 0) ? 2 : 0;
                    m_bf   = 0;
                end
            end
        end
    endtask

    // Blinking slot is lit during odd-numbered groups of P frames.
    task automatic exp_pix(input int x, input int y, output bit dr, output int ox, output int oy, output int hi);
        int dx, i, r;
        bit vis;
        dr = 0; ox = 0; oy = 0; hi = 0;
        dx = x - TX;
        if (dx >= 0 && y >= TY && y < TY + H) begin
            i = dx / (W + G);
            r = dx % (W + G);
            if (i < MAXL && r < W) begin
                vis = (m_mode != 2) &&
                      (i < m_lives || (m_mode == 1 && i == m_lives && ((m_bf / P) % 2 == 1)));
                if (vis) begin
                    dr = 1; ox = r; oy = y - TY; hi = i;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_event(input bit lose, input bit gain, input bit rs, input bit sof);
        loseLife = lose; gainLife = gain; restart = rs; startOfFrame = sof;
        tick();
        loseLife = 0; gainLife = 0; restart = 0; startOfFrame = 0;
        model_event(lose, gain, rs, sof);
        tick();
        tick();
        check("lives", 32'(livesLeft), 32'(m_lives));
        check("gameover", 32'(gameOver), 32'(m_mode == 2));
    endtask

    task automatic probe(input int x, input int y);
        bit dr;
        int ox, oy, hi;
        pixelX = 11'(x);
        pixelY = 11'(y);
        tick();
        exp_pix(x, y, dr, ox, oy, hi);
        check($sformatf("dr@%0d,%0d", x, y), 32'(drawingRequest), 32'(dr));
        check($sformatf("rgb@%0d,%0d", x, y), 32'(RGBout), dr ? 32'(COL) : 32'hFF);
        check($sformatf("ox@%0d,%0d", x, y), 32'(offsetX), 32'(ox));
        check($sformatf("oy@%0d,%0d", x, y), 32'(offsetY), 32'(oy));
        check($sformatf("hi@%0d,%0d", x, y), 32'(heartIndex), 32'(hi));
    endtask

    task automatic probe_slots();
        for (int i = 0; i < MAXL; i++) probe(TX + i * (W + G) + W / 2, TY + 3);
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) do_event(0, 0, 0, 1);
    endtask

    initial begin
        resetN = 1; pixelX = 0; pixelY = 0;
        startOfFrame = 0; loseLife = 0; gainLife = 0; restart = 0;
        model_reset();
        #1 resetN = 0;
        #2;
        check("rst_dr", 32'(drawingRequest), 0);
        check("rst_rgb", 32'(RGBout), 0);
        check("rst_ox", 32'(offsetX), 0);
        check("rst_oy", 32'(offsetY), 0);
        check("rst_hi", 32'(heartIndex), 0);
        check("rst_lives", 32'(livesLeft), 3);
        check("rst_go", 32'(gameOver), 0);
        repeat (2) @(posedge clk);
        #2 resetN = 1;
        tick();

        // Full scan across the bar
        for (int x = 548; x <= 615; x++) probe(x, 10);
        probe(570, 10);
        check("ox570", 32'(offsetX), 0);
        check("hi570", 32'(heartIndex), 1);
        probe(568, 10);
        check("rgb568", 32'(RGBout), 32'hFF);
        probe(611, 10);
        check("dr611", 32'(drawingRequest), 1);
        probe(612, 10);
        check("dr612", 32'(drawingRequest), 0);
        probe(560, 4);
        probe(560, 20);
        probe(560, 21);

        // One loss: slot 2 blinks with period P, then stays hidden
        do_event(1, 0, 0, 0);
        check("lives_after_lose", 32'(livesLeft), 2);
        for (int f = 1; f <= P * T; f++) begin
            do_event(0, 0, 0, 1);
            probe(TX + 2 * (W + G) + 5, 10);
            check("blink2", 32'(drawingRequest), 32'((((f / P) % 2) == 1) && (f < P * T)));
        end
        probe_slots();

        // Two more full losses reach game over
        do_event(1, 0, 0, 0); frames(P * T);
        do_event(1, 0, 0, 0); frames(P * T);
        check("go_lives", 32'(livesLeft), 0);
        check("go_flag", 32'(gameOver), 1);
        probe_slots();
        do_event(1, 0, 0, 0);
        do_event(0, 1, 0, 0);
        check("go_sticky", 32'(livesLeft), 0);
        do_event(0, 0, 1, 0);
        check("restart_lives", 32'(livesLeft), 3);
        check("restart_go", 32'(gameOver), 0);

        // Loss during an active blink
        do_event(1, 0, 0, 0); frames(20);
        do_event(1, 0, 0, 0);
        check("relose", 32'(livesLeft), 1);
        probe_slots();
        frames(P);
        probe_slots();

        // Simultaneous pulses and saturation
        do_event(0, 0, 1, 0);
        do_event(1, 0, 0, 0); frames(P * T);
        do_event(1, 1, 0, 0);
        check("both", 32'(livesLeft), 2);
        do_event(0, 1, 0, 0);
        do_event(0, 1, 0, 0);
        check("sat", 32'(livesLeft), 3);

        // Async reset mid-blink
        do_event(1, 0, 0, 0); frames(10);
        probe(TX + W / 2, 10);
        #2 resetN = 0;
        #1;
        check("arst_dr", 32'(drawingRequest), 0);
        check("arst_rgb", 32'(RGBout), 0);
        check("arst_lives", 32'(livesLeft), 3);
        check("arst_go", 32'(gameOver), 0);
        model_reset();
        @(negedge clk);
        resetN = 1;
        tick();
        probe_slots();

        // Randomized event stream
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 62)      do_event(0, 0, 0, 1);
            else if (r < 78) do_event(1, 0, 0, 0);
            else if (r < 88) do_event(0, 1, 0, 0);
            else if (r < 94) do_event(1, 1, 0, 0);
            else             do_event(0, 0, 1, 0);
            probe_slots();
            if ($urandom_range(0, 3) == 0)
                probe(int'($urandom_range(540, 630)), int'($urandom_range(0, 24)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lives_bar_object.md
Name: lives_bar_object

Overview:
- Parametrised successor of the single-rectangle heart indicator.
- Draws a row of MAX_LIVES heart slots at a fixed screen position and keeps its own lives counter, driven by loseLife / gainLife / restart pulses.
- Blinks the heart being lost for a programmable number of frames, then enters a game-over state.
- Feeds the VGA object mux (drawingRequest/RGBout) and the heart bitmap ROM (offsetX/offsetY/heartIndex).

Parameters:
- MAX_LIVES, 3, number of heart slots and reset/restart life count (1..15).
- HEART_W, 20, slot width in pixels.
- HEART_H, 16, slot height in pixels.
- GAP, 2, blank pixels between adjacent slots.
- top_X, 548, left x of slot 0.
- top_Y, 5, top y of all slots.
- OBJECT_COLOR, 8'h5b, RGB output for drawn heart pixels.
- BLINK_PERIOD, 8, frames per blink half-phase (>=1).
- BLINK_TOGGLES, 6, number of phase flips per blink sequence (>=1).

Ports:
- clk, input, 1, system clock.
- resetN, input, 1, asynchronous active-low reset.
- pixelX, input, 11, current VGA pixel x.
- pixelY, input, 11, current VGA pixel y.
- startOfFrame, input, 1, one-cycle pulse per frame.
- loseLife, input, 1, one-cycle pulse: decrement lives.
- gainLife, input, 1, one-cycle pulse: increment lives.
- restart, input, 1, one-cycle pulse: reload MAX_LIVES and enter IDLE.
- offsetX, output, 11, pixel offset from the current slot's left edge.
- offsetY, output, 11, pixel offset from top_Y.
- drawingRequest, output, 1, current pixel is a visible heart pixel.
- RGBout, output, 8, OBJECT_COLOR or 8'hFF (transparent).
- heartIndex, output, 4, slot number under the pixel.
- livesLeft, output, 4, current life count.
- gameOver, output, 1, high in GAME_OVER.

Behaviour:
- Reset (async, resetN=0):
  - RGBout=0, drawingRequest=0, offsetX=0, offsetY=0, heartIndex=0.
  - livesLeft=MAX_LIVES, gameOver=0, state=IDLE, frameCnt=0, toggleCnt=0, blinkOn=0.
- Geometry:
  - Slot i spans x in [top_X+i*(HEART_W+GAP), top_X+i*(HEART_W+GAP)+HEART_W) and y in [top_Y, top_Y+HEART_H), for i=0..MAX_LIVES-1.
  - Gap pixels and pixels outside the bar are never drawn.
  - Slot membership uses comparisons against constants per slot; no runtime divider.
- Visibility:
  - Slot i is visible if i < livesLeft.
  - Slot i is also visible if state=BLINK, i==livesLeft and blinkOn=1.
- Pixel pipeline: one-cycle registered latency.
  - Pixel on a visible slot: drawingRequest=1, RGBout=OBJECT_COLOR, offsetX=pixelX-slotLeft, offsetY=pixelY-top_Y, heartIndex=i.
  - Otherwise: drawingRequest=0, RGBout=8'hFF, offsetX=0, offsetY=0, heartIndex=0.
- State machine: IDLE, BLINK, GAME_OVER.
  - IDLE, loseLife alone with livesLeft>0: livesLeft-=1 -> BLINK; frameCnt, toggleCnt, blinkOn cleared.
  - IDLE, gainLife alone: livesLeft+=1, saturating at MAX_LIVES.
  - BLINK, each startOfFrame: frameCnt+=1. When frameCnt==BLINK_PERIOD-1: frameCnt=0, blinkOn toggles, toggleCnt+=1.
  - BLINK, when toggleCnt reaches BLINK_TOGGLES: -> GAME_OVER if livesLeft==0, else -> IDLE; blinkOn=0.
  - BLINK, loseLife with livesLeft>0: decrement and restart the sequence (counters cleared). The previously blinking slot vanishes immediately.
  - BLINK, loseLife with livesLeft==0: ignored.
  - BLINK, gainLife: increment (saturating) -> IDLE, blink aborted.
  - GAME_OVER: gameOver=1, no slot drawn, loseLife/gainLife ignored.
- Simultaneous events:
  - loseLife and gainLife in the same cycle (no restart): no change to livesLeft or state.
  - restart has priority over all other pulses in any state: livesLeft=MAX_LIVES, state=IDLE, counters cleared, gameOver=0 next cycle.
- Widths and reset:
  - livesLeft and heartIndex are 4 bits; offsets are computed in 11-bit unsigned.
  - frameCnt is sized for BLINK_PERIOD, toggleCnt for BLINK_TOGGLES.
  - Reset asserted mid-blink returns everything to the reset values above.

Test Plan:
- Reset, then scan y=10, x=548..615 -> drawingRequest=1 for x 548-567, 570-589, 592-611 (one cycle later); heartIndex 0/1/2; offsetX at x=570 is 0; RGBout=8'hFF at x=568.
- loseLife once, then 48 startOfFrame pulses -> livesLeft=2; slot 2 hidden for frames 0-7, shown 8-15, alternating; after frame 48 state=IDLE and slot 2 permanently hidden.
- Three loseLife pulses separated by full blink sequences -> livesLeft=0; gameOver=1 after the third blink completes; no pixel drawn; a further loseLife causes no change.
- loseLife at frame 20 of an active blink -> livesLeft decrements again, blink counters restart, slot 2 disappears at once, slot 1 blinks.
- loseLife and gainLife in the same cycle at livesLeft=2 -> livesLeft stays 2; gainLife at 3 -> stays 3; restart in GAME_OVER -> livesLeft=3, gameOver=0 next cycle.
- resetN pulsed low mid-blink -> outputs go to reset values immediately (asynchronously); after release, all 3 slots draw.
